input_conditioner: RTL and testbench

Single-clock front end that cleans the raw measured signal before it reaches `frequency_counter.signal_input`. It applies metastability synchronisation, a programmable-length glitch filter, edge detection, an edge prescaler for high-frequency inputs, and a signal-loss watchdog. Configuration inputs come from `control_unit` registers. Status outputs (`signal_lost_o`, `glitch_cnt_o`) are readable by `control_unit` and drive the status LEDs.

---
 rtl/fc_pkg.sv | 19 +
 rtl/input_conditioner_if.sv | 36 +++
 rtl/input_conditioner_sync_filter.sv | 79 +++++++
 rtl/input_conditioner.sv | 110 +++++++++++
 tb/tb_input_conditioner.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// Shared widths and constants for the frequency counter front end.
// Also holds the saturating glitch-count increment helper.
package fc_pkg;

  localparam int SYNC_STAGES_D = 2;
  localparam int FILTER_W_D    = 4;
  localparam int PRESCALE_W_D  = 16;
  localparam int TIMEOUT_W_D   = 24;
  localparam int GLITCH_CNT_W  = 16;

  localparam logic [GLITCH_CNT_W-1:0] GLITCH_SAT = '1;

  function automatic logic [GLITCH_CNT_W-1:0] sat_inc(
    input logic [GLITCH_CNT_W-1:0] v
  );
    return (v == GLITCH_SAT) ? v : v + GLITCH_CNT_W'(1);
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Configuration, raw input and status bundle of the input conditioner.
// master drives config and the raw signal; slave is the conditioner.
interface input_conditioner_if
  import fc_pkg::*;
#(
  parameter int FILTER_W   = FILTER_W_D,
  parameter int PRESCALE_W = PRESCALE_W_D,
  parameter int TIMEOUT_W  = TIMEOUT_W_D
);

  logic                    enable_i;
  logic                    signal_i;
  logic [FILTER_W-1:0]     filter_len_i;
  logic [PRESCALE_W-1:0]   prescale_i;
  logic [TIMEOUT_W-1:0]    timeout_i;
  logic                    signal_o;
  logic                    rise_stb_o;
  logic                    prescaled_o;
  logic                    signal_lost_o;
  logic [GLITCH_CNT_W-1:0] glitch_cnt_o;

  modport master (
    output enable_i, signal_i,
    output filter_len_i, prescale_i, timeout_i,
    input  signal_o, rise_stb_o, prescaled_o,
    input  signal_lost_o, glitch_cnt_o
  );

  modport slave (
    input  enable_i, signal_i,
    input  filter_len_i, prescale_i, timeout_i,
    output signal_o, rise_stb_o, prescaled_o,
    output signal_lost_o, glitch_cnt_o
  );

endinterface

// File: rtl/input_conditioner_sync_filter.sv
// Synchroniser chain plus run-length glitch filter and glitch counter.
// st_nxt_o exposes the next stable level so edges can be registered.
module sync_filter
  import fc_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_D,
  parameter int FILTER_W    = FILTER_W_D
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    sig_i,
  input  logic [FILTER_W-1:0]     len_i,
  output logic                    st_o,
  output logic                    st_nxt_o,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_o
);

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    s;
  logic                    st_q, st_n;
  logic [FILTER_W-1:0]     rc_q, rc_n;
  logic [FILTER_W-1:0]     len_eff;
  logic [FILTER_W:0]       rc_inc;
  logic                    glitch;
  logic [GLITCH_CNT_W-1:0] glitch_q;

  assign s       = sync_q[SYNC_STAGES-1];
  assign len_eff = (len_i == '0) ? FILTER_W'(1) : len_i;
  assign rc_inc  = {1'b0, rc_q} + (FILTER_W+1)'(1);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
    end
  end

  always_comb begin
    st_n   = st_q;
    rc_n   = rc_q;
    glitch = 1'b0;
    if (!en_i) begin
      st_n = 1'b0;
      rc_n = '0;
    end else if (s != st_q) begin
      // >= so a shortened length mid-run still terminates the run
      if (rc_inc >= {1'b0, len_eff}) begin
        st_n = s;
        rc_n = '0;
      end else begin
        rc_n = rc_inc[FILTER_W-1:0];
      end
    end else if (rc_q != '0) begin
      rc_n   = '0;
      glitch = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= 1'b0;
      rc_q     <= '0;
      glitch_q <= '0;
    end else begin
      st_q <= st_n;
      rc_q <= rc_n;
      if (glitch) begin
        glitch_q <= sat_inc(glitch_q);
      end
    end
  end

  assign st_o         = st_q;
  assign st_nxt_o     = st_n;
  assign glitch_cnt_o = glitch_q;

endmodule

// File: rtl/input_conditioner.sv
// Signal front end: sync/filter, edge detect, prescaler and loss watchdog.
// Every output comes straight from a flop.
module input_conditioner
  import fc_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_D,
  parameter int FILTER_W    = FILTER_W_D,
  parameter int PRESCALE_W  = PRESCALE_W_D,
  parameter int TIMEOUT_W   = TIMEOUT_W_D
) (
  input logic                clk_i,
  input logic                ext_rst_i,
  input_conditioner_if.slave bus
);

  logic                    en;
  logic                    st, st_nxt;
  logic [GLITCH_CNT_W-1:0] glitch_cnt;
  logic                    edge_w;
  logic                    rise_n, rise_q;
  logic [PRESCALE_W-1:0]   pmax;
  logic                    pc_hit;
  logic [PRESCALE_W-1:0]   pc_q, pc_n;
  logic                    pre_q, pre_n;
  logic [TIMEOUT_W-1:0]    wc_q, wc_n;
  logic                    lost_q, lost_n;

  assign en = bus.enable_i;

  sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_W    (FILTER_W)
  ) u_sync_filter (
    .clk_i        (clk_i),
    .rst_n        (ext_rst_i),
    .en_i         (en),
    .sig_i        (bus.signal_i),
    .len_i        (bus.filter_len_i),
    .st_o         (st),
    .st_nxt_o     (st_nxt),
    .glitch_cnt_o (glitch_cnt)
  );

  assign edge_w = st_nxt ^ st;
  assign rise_n = st_nxt & ~st;

  assign pmax   = (bus.prescale_i == '0)
                ? PRESCALE_W'(1) : bus.prescale_i;
  assign pc_hit = ({1'b0, pc_q} + (PRESCALE_W+1)'(1))
                >= {1'b0, pmax};

  always_comb begin
    pc_n  = pc_q;
    pre_n = pre_q;
    if (!en) begin
      pc_n  = '0;
      pre_n = 1'b0;
    end else if (rise_q) begin
      if (pc_hit) begin
        pc_n  = '0;
        pre_n = ~pre_q;
      end else begin
        pc_n = pc_q + PRESCALE_W'(1);
      end
    end
  end

  // An edge wins over expiry in the same cycle
  always_comb begin
    wc_n   = wc_q;
    lost_n = lost_q;
    if (!en || bus.timeout_i == '0) begin
      wc_n   = '0;
      lost_n = 1'b0;
    end else if (edge_w) begin
      wc_n   = '0;
      lost_n = 1'b0;
    end else begin
      if (wc_q != '1) begin
        wc_n = wc_q + TIMEOUT_W'(1);
      end
      if (wc_q == bus.timeout_i - TIMEOUT_W'(1)) begin
        lost_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge ext_rst_i) begin
    if (!ext_rst_i) begin
      rise_q <= 1'b0;
      pc_q   <= '0;
      pre_q  <= 1'b0;
      wc_q   <= '0;
      lost_q <= 1'b0;
    end else begin
      rise_q <= rise_n;
      pc_q   <= pc_n;
      pre_q  <= pre_n;
      wc_q   <= wc_n;
      lost_q <= lost_n;
    end
  end

  assign bus.signal_o      = st;
  assign bus.rise_stb_o    = rise_q;
  assign bus.prescaled_o   = pre_q;
  assign bus.signal_lost_o = lost_q;
  assign bus.glitch_cnt_o  = glitch_cnt;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner; rise strobes are scored
// against a queue of expected cycle numbers.
module tb_input_conditioner;
  import fc_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   tog    = 0;
  int   exp_rise[$];
  logic pre_prev = 1'b0;

  always #5 clk = ~clk;

  input_conditioner_if bus ();

  input_conditioner dut (
    .clk_i     (clk),
    .ext_rst_i (rst_n),
    .bus       (bus.slave)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.prescaled_o !== pre_prev) tog++;
    pre_prev = bus.prescaled_o;
    if (bus.rise_stb_o === 1'b1) begin
      if (exp_rise.size() == 0)
        check("rise_unexpected", exp_rise.size(), 1);
      else
        check("rise_cycle", cyc, exp_rise.pop_front());
    end
  end

  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic square(int n, int hold, int lat);
    for (int i = 0; i < n; i++) begin
      exp_rise.push_back(cyc + lat);
      bus.signal_i = 1'b1;
      wait_n(hold);
      bus.signal_i = 1'b0;
      wait_n(hold);
    end
  endtask

  initial begin
    bus.enable_i     = 1'b1;
    bus.signal_i     = 1'b0;
    bus.filter_len_i = 4'd3;
    bus.prescale_i   = 16'd1;
    bus.timeout_i    = 24'd0;
    wait_n(3);
    check("rst_signal", bus.signal_o, 0);
    check("rst_rise", bus.rise_stb_o, 0);
    check("rst_prescaled", bus.prescaled_o, 0);
    check("rst_lost", bus.signal_lost_o, 0);
    check("rst_glitch", bus.glitch_cnt_o, 0);
    rst_n = 1'b1;
    wait_n(5);
    check("idle_signal", bus.signal_o, 0);

    // step with filter length 3: 2 sync + 3 filter edges
    exp_rise.push_back(cyc + 5);
    bus.signal_i = 1'b1;
    wait_n(4);
    check("step_pre", bus.signal_o, 0);
    wait_n(1);
    check("step_post", bus.signal_o, 1);
    wait_n(1);
    check("step_single", bus.rise_stb_o, 0);
    bus.signal_i = 1'b0;
    wait_n(8);

    // glitch rejection, filter length 4
    bus.filter_len_i = 4'd4;
    bus.signal_i = 1'b1; wait_n(2);
    bus.signal_i = 1'b0; wait_n(8);
    bus.signal_i = 1'b1; wait_n(3);
    bus.signal_i = 1'b0; wait_n(8);
    check("glitch_level", bus.signal_o, 0);
    check("glitch_cnt2", bus.glitch_cnt_o, 2);
    exp_rise.push_back(cyc + 6);
    bus.signal_i = 1'b1; wait_n(4);
    bus.signal_i = 1'b0; wait_n(10);
    check("glitch_accept", bus.glitch_cnt_o, 2);

    // prescaler
    bus.filter_len_i = 4'd1;
    bus.prescale_i   = 16'd5;
    wait_n(2);
    tog = 0;
    square(20, 2, 3);
    wait_n(3);
    check("presc5_tog", tog, 4);
    bus.prescale_i = 16'd0;
    tog = 0;
    square(6, 2, 3);
    wait_n(3);
    check("presc0_tog", tog, 6);
    bus.prescale_i = 16'd5;
    tog = 0;
    square(3, 2, 3);
    wait_n(3);
    check("presc_mid_pre", tog, 0);
    bus.prescale_i = 16'd2;
    square(1, 2, 3);
    wait_n(3);
    check("presc_mid_post", tog, 1);

    // watchdog, last edge is the falling transition
    bus.timeout_i = 24'd100;
    exp_rise.push_back(cyc + 3);
    bus.signal_i = 1'b1; wait_n(4);
    bus.signal_i = 1'b0;
    wait_n(102);
    check("wd_pre", bus.signal_lost_o, 0);
    wait_n(1);
    check("wd_set", bus.signal_lost_o, 1);
    exp_rise.push_back(cyc + 3);
    bus.signal_i = 1'b1;
    wait_n(2);
    check("wd_hold", bus.signal_lost_o, 1);
    wait_n(1);
    check("wd_clear", bus.signal_lost_o, 0);
    wait_n(97);
    bus.signal_i = 1'b0;
    wait_n(2);
    check("wd_expiry_pre", bus.signal_lost_o, 0);
    wait_n(1);
    check("wd_expiry_sig", bus.signal_o, 0);
    check("wd_expiry_lost", bus.signal_lost_o, 0);
    wait_n(100);
    check("wd_rearm", bus.signal_lost_o, 1);
    bus.timeout_i = 24'd0;
    wait_n(150);
    check("wd_off", bus.signal_lost_o, 0);

    // disable mid-count
    bus.filter_len_i = 4'd2;
    bus.prescale_i   = 16'd5;
    bus.timeout_i    = 24'd50;
    square(3, 3, 4);
    exp_rise.push_back(cyc + 4);
    bus.signal_i = 1'b1;
    wait_n(6);
    check("dis_pre_sig", bus.signal_o, 1);
    bus.enable_i = 1'b0;
    wait_n(1);
    check("dis_sig", bus.signal_o, 0);
    check("dis_rise", bus.rise_stb_o, 0);
    check("dis_presc", bus.prescaled_o, 0);
    check("dis_lost", bus.signal_lost_o, 0);
    check("dis_glitch", bus.glitch_cnt_o, 2);
    wait_n(5);
    tog = 0;
    exp_rise.push_back(cyc + 2);
    bus.enable_i = 1'b1;
    wait_n(4);
    check("reen_sig", bus.signal_o, 1);
    bus.signal_i = 1'b0;
    wait_n(3);
    square(3, 3, 4);
    wait_n(3);
    check("reen_pc_clear", tog, 0);
    square(1, 3, 4);
    wait_n(4);
    check("reen_tog", tog, 1);

    // glitch counter saturation from a preloaded value
    force dut.u_sync_filter.glitch_q = 16'hFFFD;
    wait_n(1);
    release dut.u_sync_filter.glitch_q;
    for (int i = 0; i < 3; i++) begin
      bus.signal_i = 1'b1; wait_n(1);
      bus.signal_i = 1'b0; wait_n(4);
      if (i == 0) check("sat_fffe", bus.glitch_cnt_o, 16'hFFFE);
      if (i == 1) check("sat_ffff", bus.glitch_cnt_o, 16'hFFFF);
    end
    check("sat_hold", bus.glitch_cnt_o, 16'hFFFF);

    // async reset mid-pulse
    exp_rise.push_back(cyc + 4);
    bus.signal_i = 1'b1;
    wait_n(6);
    check("arst_pre", bus.signal_o, 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_sig", bus.signal_o, 0);
    check("arst_glitch", bus.glitch_cnt_o, 0);
    check("arst_rise", bus.rise_stb_o, 0);
    check("arst_lost", bus.signal_lost_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.signal_i = 1'b0;
    wait_n(4);
    bus.signal_i = 1'b1; wait_n(1);
    bus.signal_i = 1'b0; wait_n(4);
    check("glitch_restart", bus.glitch_cnt_o, 1);
    check("rise_queue_empty", exp_rise.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
